// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback commit unit and its late-result queue.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  localparam wb_req_t WB_REQ_NONE = '0;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer for long-latency results; exposes the two oldest entries so up
// to two can retire per cycle. Pointers wrap naturally (DEPTH is a power of two).
module wb_late_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq,
  input  wb_req_t                 enq_req,
  input  logic [1:0]              deq_cnt,
  output wb_req_t                 head0,
  output wb_req_t                 head1,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr1;
  wb_req_t          mem [DEPTH];

  assign rd_ptr1 = rd_ptr + PTR_W'(1);

  // Entry valid bits come from the occupancy, never from stored contents.
  always_comb begin
    head0       = mem[rd_ptr];
    head0.valid = (count != '0);
    head1       = mem[rd_ptr1];
    head1.valid = (count > CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + PTR_W'(deq_cnt);
      count  <= count + CNT_W'(enq) - CNT_W'(deq_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem[wr_ptr] <= enq_req;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: merges two in-order pipe results with queued late results onto
// two register-file write ports. Optional r0 write suppression via WB_R0_FILTER_EN.
module wb_commit
  import wb_pkg::*;
#(
  parameter int unsigned LATE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe0_valid,
  input  logic [REG_ADDR_W-1:0] pipe0_rd,
  input  logic [REG_DATA_W-1:0] pipe0_data,
  input  logic                  pipe1_valid,
  input  logic [REG_ADDR_W-1:0] pipe1_rd,
  input  logic [REG_DATA_W-1:0] pipe1_data,
  input  logic                  late_valid,
  input  logic [REG_ADDR_W-1:0] late_rd,
  input  logic [REG_DATA_W-1:0] late_data,
  output logic                  late_ready,
  output logic                  we1,
  output logic [REG_ADDR_W-1:0] waddr1,
  output logic [REG_DATA_W-1:0] wdata1,
  output logic                  we2,
  output logic [REG_ADDR_W-1:0] waddr2,
  output logic [REG_DATA_W-1:0] wdata2
);

  localparam int unsigned CNT_W = $clog2(LATE_DEPTH) + 1;

`ifdef WB_R0_FILTER_EN
  localparam bit R0_FILTER = 1'b1;
`else
  localparam bit R0_FILTER = 1'b0;
`endif

  wb_req_t          head0;
  wb_req_t          head1;
  wb_req_t          offer;
  wb_req_t          cand [3];
  wb_req_t          port1_late;
  wb_req_t          port2_late;
  logic [CNT_W-1:0] q_count;
  logic             offer_acc;
  logic             enq;
  logic [1:0]       deq_cnt;
  logic [2:0]       retired;
  logic             p1_free;
  logic             p2_free;
  logic             blocked;

  logic                  we1_n;
  logic [REG_ADDR_W-1:0] waddr1_n;
  logic [REG_DATA_W-1:0] wdata1_n;
  logic                  we2_n;
  logic [REG_ADDR_W-1:0] waddr2_n;
  logic [REG_DATA_W-1:0] wdata2_n;

  wb_late_fifo #(
    .DEPTH   (LATE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq     (enq),
    .enq_req (offer),
    .deq_cnt (deq_cnt),
    .head0   (head0),
    .head1   (head1),
    .count   (q_count)
  );

  assign late_ready = (q_count < CNT_W'(LATE_DEPTH));
  assign offer_acc  = late_valid && late_ready;
  assign offer      = '{valid: offer_acc, rd: late_rd, data: late_data};

  // Late port allocator: walk candidates oldest first; the first one that can
  // neither be dropped nor placed blocks every younger one to keep order.
  always_comb begin
    cand[0]    = head0;
    cand[1]    = head1;
    cand[2]    = offer;
    p1_free    = !pipe0_valid;
    p2_free    = !pipe1_valid;
    blocked    = 1'b0;
    retired    = '0;
    port1_late = WB_REQ_NONE;
    port2_late = WB_REQ_NONE;
    for (int i = 0; i < 3; i++) begin
      // With more than two queued entries the offer is not next in age order.
      if (i == 2 && q_count > CNT_W'(2)) begin
        blocked = 1'b1;
      end
      if (cand[i].valid && !blocked) begin
        if ((pipe0_valid && cand[i].rd == pipe0_rd) ||
            (pipe1_valid && cand[i].rd == pipe1_rd) ||
            (R0_FILTER && cand[i].rd == '0)) begin
          retired[i] = 1'b1;
        end else if (p1_free) begin
          p1_free    = 1'b0;
          port1_late = cand[i];
          retired[i] = 1'b1;
        end else if (p2_free) begin
          p2_free    = 1'b0;
          port2_late = cand[i];
          retired[i] = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    deq_cnt = 2'(retired[0]) + 2'(retired[1]);
    enq     = offer_acc && !retired[2];
  end

  // Port payload select; idle ports drive zero address and data.
  always_comb begin
    we1_n    = pipe0_valid ? !(R0_FILTER && pipe0_rd == '0) : port1_late.valid;
    waddr1_n = pipe0_valid ? pipe0_rd : port1_late.rd;
    wdata1_n = pipe0_valid ? pipe0_data : port1_late.data;
    we2_n    = pipe1_valid ? !(R0_FILTER && pipe1_rd == '0) : port2_late.valid;
    waddr2_n = pipe1_valid ? pipe1_rd : port2_late.rd;
    wdata2_n = pipe1_valid ? pipe1_data : port2_late.data;
    if (!we1_n) begin
      waddr1_n = '0;
      wdata1_n = '0;
    end
    if (!we2_n) begin
      waddr2_n = '0;
      wdata2_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we1    <= 1'b0;
      waddr1 <= '0;
      wdata1 <= '0;
      we2    <= 1'b0;
      waddr2 <= '0;
      wdata2 <= '0;
    end else begin
      we1    <= we1_n;
      waddr1 <= waddr1_n;
      wdata1 <= wdata1_n;
      we2    <= we2_n;
      waddr2 <= waddr2_n;
      wdata2 <= wdata2_n;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus randomized traffic
// against a queue-based reference model of the commit rules.
module tb_wb_commit;

  localparam int DEPTH = 4;
`ifdef WB_R0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe0_valid, pipe1_valid, late_valid;
  logic [4:0]  pipe0_rd, pipe1_rd, late_rd;
  logic [31:0] pipe0_data, pipe1_data, late_data;
  logic        late_ready;
  logic        we1, we2;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  bit          e_we1, e_we2, e_rst;
  logic [4:0]  e_a1, e_a2;
  logic [31:0] e_d1, e_d2;

  always #5 clk = ~clk;

  wb_commit #(.LATE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe0_valid(pipe0_valid), .pipe0_rd(pipe0_rd), .pipe0_data(pipe0_data),
    .pipe1_valid(pipe1_valid), .pipe1_rd(pipe1_rd), .pipe1_data(pipe1_data),
    .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
    .late_ready(late_ready),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2)
  );

  task automatic clear_inputs();
    reset = 1'b0;
    pipe0_valid = 1'b0; pipe0_rd = '0; pipe0_data = '0;
    pipe1_valid = 1'b0; pipe1_rd = '0; pipe1_data = '0;
    late_valid  = 1'b0; late_rd  = '0; late_data  = '0;
  endtask

  // Reference model: all late results in age order live in one list (queue then
  // offer); retire from the front while each can be dropped or given a free port.
  task automatic cycle();
    ent_t cq[$];
    ent_t ent;
    bit   p1_free, p2_free;
    int   n;
    if (reset) begin
      mq.delete();
      e_rst = 1'b1;
      e_we1 = 1'b0; e_a1 = '0; e_d1 = '0;
      e_we2 = 1'b0; e_a2 = '0; e_d2 = '0;
    end else begin
      e_rst = 1'b0;
      cq = mq;
      if (late_valid && mq.size() < DEPTH) cq.push_back('{rd: late_rd, data: late_data});
      e_we1 = pipe0_valid && !(FILT && pipe0_rd == 5'd0); e_a1 = pipe0_rd; e_d1 = pipe0_data;
      e_we2 = pipe1_valid && !(FILT && pipe1_rd == 5'd0); e_a2 = pipe1_rd; e_d2 = pipe1_data;
      p1_free = !pipe0_valid;
      p2_free = !pipe1_valid;
      n = 0;
      for (int i = 0; i < cq.size(); i++) begin
        if (i >= 2 && i < mq.size()) break;
        ent = cq[i];
        if ((pipe0_valid && ent.rd == pipe0_rd) || (pipe1_valid && ent.rd == pipe1_rd) ||
            (FILT && ent.rd == 5'd0)) begin
          n++;
        end else if (p1_free) begin
          p1_free = 1'b0; e_we1 = 1'b1; e_a1 = ent.rd; e_d1 = ent.data; n++;
        end else if (p2_free) begin
          p2_free = 1'b0; e_we2 = 1'b1; e_a2 = ent.rd; e_d2 = ent.data; n++;
        end else begin
          break;
        end
      end
      repeat (n) void'(cq.pop_front());
      mq = cq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL reset_we1: got %b want 0", we1); end
    n_checks++; if (we2 !== 1'b0) begin n_fail++; $display("FAIL reset_we2: got %b want 0", we2); end
    n_checks++; if (waddr1 !== 5'd0 || wdata1 !== 32'd0) begin n_fail++; $display("FAIL reset_port1: got %0d/%h want 0/0", waddr1, wdata1); end
    n_checks++; if (waddr2 !== 5'd0 || wdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_port2: got %0d/%h want 0/0", waddr2, wdata2); end
    n_checks++; if (late_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", late_ready); end
  endtask

  task automatic test_pipe_basic();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd3; pipe0_data = 32'h11;
    pipe1_valid = 1'b1; pipe1_rd = 5'd4; pipe1_data = 32'h22;
    cycle();
    n_checks++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd3, 32'h11}) begin n_fail++; $display("FAIL basic_port1: got %b/%0d/%h want 1/3/11", we1, waddr1, wdata1); end
    n_checks++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd4, 32'h22}) begin n_fail++; $display("FAIL basic_port2: got %b/%0d/%h want 1/4/22", we2, waddr2, wdata2); end
    clear_inputs();
    cycle();
    n_checks++; if ({we1, we2} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got we1=%b we2=%b want 0 0", we1, we2); end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd20; pipe0_data = 32'hA0;
    pipe1_valid = 1'b1; pipe1_rd = 5'd21; pipe1_data = 32'hA1;
    late_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      late_rd = 5'(5 + i); late_data = 32'(32'h50 + i);
      cycle();
      n_checks++; if (late_ready !== (i < 3)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", i, late_ready, (i < 3)); end
    end
    late_rd = 5'd9; late_data = 32'hAA;
    cycle();
    n_checks++; if (late_ready !== 1'b0 || waddr1 !== 5'd20 || waddr2 !== 5'd21) begin n_fail++; $display("FAIL full_hold: got ready=%b a1=%0d a2=%0d want 0/20/21", late_ready, waddr1, waddr2); end
    pipe0_valid = 1'b0; pipe1_valid = 1'b0;
    cycle();
    n_checks++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd5, 32'h50}) begin n_fail++; $display("FAIL drain_a_p1: got %b/%0d/%h want 1/5/50", we1, waddr1, wdata1); end
    n_checks++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd6, 32'h51}) begin n_fail++; $display("FAIL drain_a_p2: got %b/%0d/%h want 1/6/51", we2, waddr2, wdata2); end
    cycle();
    n_checks++; if ({we1, waddr1, we2, waddr2} !== {1'b1, 5'd7, 1'b1, 5'd8}) begin n_fail++; $display("FAIL drain_b: got %b/%0d %b/%0d want 1/7 1/8", we1, waddr1, we2, waddr2); end
    late_valid = 1'b0;
    cycle();
    n_checks++; if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd9, 32'hAA, 1'b0}) begin n_fail++; $display("FAIL drain_c: got %b/%0d/%h we2=%b want 1/9/aa 0", we1, waddr1, wdata1, we2); end
    cycle();
    n_checks++; if ({we1, we2, late_ready} !== 3'b001) begin n_fail++; $display("FAIL drain_empty: got we1=%b we2=%b ready=%b want 0 0 1", we1, we2, late_ready); end
  endtask

  task automatic test_direct_retire();
    clear_inputs();
    pipe1_valid = 1'b1; pipe1_rd = 5'd2; pipe1_data = 32'h33;
    late_valid = 1'b1; late_rd = 5'd7; late_data = 32'h5A;
    cycle();
    n_checks++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd7, 32'h5A}) begin n_fail++; $display("FAIL direct_p1: got %b/%0d/%h want 1/7/5a", we1, waddr1, wdata1); end
    n_checks++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd2, 32'h33}) begin n_fail++; $display("FAIL direct_p2: got %b/%0d/%h want 1/2/33", we2, waddr2, wdata2); end
    clear_inputs();
    cycle();
    n_checks++; if ({we1, we2, late_ready} !== 3'b001) begin n_fail++; $display("FAIL direct_no_enq: got we1=%b we2=%b ready=%b want 0 0 1", we1, we2, late_ready); end
  endtask

  task automatic test_waw_drop();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd20; pipe1_valid = 1'b1; pipe1_rd = 5'd21;
    late_valid = 1'b1; late_rd = 5'd10; late_data = 32'h1;
    cycle();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd10; pipe0_data = 32'h2;
    cycle();
    n_checks++; if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd10, 32'h2, 1'b0}) begin n_fail++; $display("FAIL waw_drop: got %b/%0d/%h we2=%b want 1/10/2 0", we1, waddr1, wdata1, we2); end
    clear_inputs();
    cycle();
    n_checks++; if ({we1, we2} !== 2'b00) begin n_fail++; $display("FAIL waw_no_stale: got we1=%b we2=%b wdata1=%h want 0 0", we1, we2, wdata1); end
  endtask

  task automatic test_r0();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd0; pipe0_data = 32'h77;
    late_valid = 1'b1; late_rd = 5'd0; late_data = 32'h88;
    cycle();
    n_checks++; if ({we1, we2} !== {!FILT, 1'b0}) begin n_fail++; $display("FAIL r0_we: got we1=%b we2=%b want %b 0", we1, we2, !FILT); end
    if (!FILT) begin
      n_checks++; if ({waddr1, wdata1} !== {5'd0, 32'h77}) begin n_fail++; $display("FAIL r0_port1: got %0d/%h want 0/77", waddr1, wdata1); end
    end
    clear_inputs();
    cycle();
    n_checks++; if ({we1, we2, late_ready} !== 3'b001) begin n_fail++; $display("FAIL r0_after: got we1=%b we2=%b ready=%b want 0 0 1", we1, we2, late_ready); end
  endtask

  task automatic test_reset_full();
    clear_inputs();
    pipe0_valid = 1'b1; pipe0_rd = 5'd20; pipe1_valid = 1'b1; pipe1_rd = 5'd21;
    late_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      late_rd = 5'(11 + i); late_data = 32'(32'hC0 + i);
      cycle();
    end
    n_checks++; if (late_ready !== 1'b0) begin n_fail++; $display("FAIL rstfull_pre: got ready=%b want 0", late_ready); end
    reset = 1'b1; late_rd = 5'd15;
    cycle();
    clear_inputs();
    n_checks++; if ({we1, waddr1, wdata1, we2, waddr2, wdata2} !== '0) begin n_fail++; $display("FAIL rstfull_out: got %b/%0d/%h %b/%0d/%h want all 0", we1, waddr1, wdata1, we2, waddr2, wdata2); end
    n_checks++; if (late_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_ready: got %b want 1", late_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if ({we1, we2} !== 2'b00) begin n_fail++; $display("FAIL rstfull_stale%0d: got we1=%b a1=%0d we2=%b want 0 0", i, we1, waddr1, we2); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(0, 63) == 0);
      pipe0_valid = ($urandom_range(0, 2) != 0); pipe0_rd = 5'($urandom_range(0, 7)); pipe0_data = 32'($urandom);
      pipe1_valid = ($urandom_range(0, 2) != 0); pipe1_rd = 5'($urandom_range(0, 7)); pipe1_data = 32'($urandom);
      late_valid  = ($urandom_range(0, 1) != 0); late_rd  = 5'($urandom_range(0, 7)); late_data  = 32'($urandom);
      cycle();
      n_checks++; if (we1 !== e_we1) begin n_fail++; $display("FAIL rand_we1 @%0d: got %b want %b", k, we1, e_we1); end
      n_checks++; if (we2 !== e_we2) begin n_fail++; $display("FAIL rand_we2 @%0d: got %b want %b", k, we2, e_we2); end
      if (e_we1 || e_rst) begin
        n_checks++; if (waddr1 !== e_a1 || wdata1 !== e_d1) begin n_fail++; $display("FAIL rand_port1 @%0d: got %0d/%h want %0d/%h", k, waddr1, wdata1, e_a1, e_d1); end
      end
      if (e_we2 || e_rst) begin
        n_checks++; if (waddr2 !== e_a2 || wdata2 !== e_d2) begin n_fail++; $display("FAIL rand_port2 @%0d: got %0d/%h want %0d/%h", k, waddr2, wdata2, e_a2, e_d2); end
      end
      n_checks++; if (late_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready @%0d: got %b want %b", k, late_ready, (mq.size() < DEPTH)); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_pipe_basic();
    test_backpressure();
    test_direct_retire();
    test_waw_drop();
    test_r0();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit for the dual-issue pipeline; it is the write-side driver of the two-write-port integer register file. Each cycle it merges the two in-order pipe results with out-of-band long-latency results (divider, cache-miss loads) buffered in a small queue. It drives the register file's two write ports through registered outputs and resolves same-cycle WAW conflicts so that the youngest value lands.

## Interface
- `LATE_DEPTH`, 4: late-result queue entries, power of two, ≥ 2.
- `clk` in 1: clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `pipe0_valid` / `pipe0_rd` / `pipe0_data` in 1/5/32: older in-order result.
- `pipe1_valid` / `pipe1_rd` / `pipe1_data` in 1/5/32: younger in-order result.
- `late_valid` / `late_rd` / `late_data` in 1/5/32: long-latency result offer.
- `late_ready` out 1: queue can accept; transfer when `late_valid && late_ready`.
- `we1` / `waddr1` / `wdata1` out 1/5/32: register-file write port 1.
- `we2` / `waddr2` / `wdata2` out 1/5/32: register-file write port 2. The register file gives port 2 precedence on equal addresses.

## Operation
- Pipe results have no backpressure and are always written.
- Fixed mapping:
  - pipe0 → port 1.
  - pipe1 → port 2.
  - Equal `pipe0_rd`/`pipe1_rd` → pipe1 value lands via port-2 precedence.
- Late candidates, oldest first: queue head, queue head+1, then the incoming late offer.
- Free ports are filled port 1 first, then port 2. At most 2 late writes retire per cycle.
- Incoming late offer handling:
  - Retires directly when a free port remains after the queued entries.
  - Otherwise it is enqueued if accepted.
  - It is never both retired and enqueued.
- Late-vs-pipe WAW: a late candidate whose rd equals a valid same-cycle pipe rd is dropped and counted as retired. It consumes no port, because the pipe instruction is younger.
- Two late candidates retiring together with equal rd: the older goes on port 1 and the younger on port 2.
- `late_ready` = queue count < `LATE_DEPTH`. It is combinational from registered count only, with no dependence on same-cycle dequeue.
- Queue pointers wrap modulo `LATE_DEPTH`. Count is held in log2(`LATE_DEPTH`)+1 bits.
- Simultaneous enqueue and dequeue in the same cycle are legal; count changes by the net amount.

## Timing
- Inputs at cycle t appear on `we*/waddr*/wdata*` in cycle t+1 and are written to the register file at the end of t+1. Latency is 1 cycle, fully registered outputs.
- Queued late entry: at least 1 cycle in the queue, then the same 1-cycle output register.
- Reset (any cycle, including with a full queue):
  - Next cycle: `we1=we2=0`, `waddr*=0`, `wdata*=0`.
  - Queue emptied with pointers 0, so `late_ready=1`.
  - In-flight inputs in the reset cycle are discarded.
- `late_ready=1` during the reset cycle is permitted; transfers in that cycle are discarded.
- Full queue with both ports used by pipes: `late_ready=0` and queue content is unchanged.

## Configuration
- `WB_R0_FILTER_EN` defined:
  - Any candidate (pipe or late) with rd=0 is suppressed: `we` stays low for that slot.
  - A suppressed late candidate still retires and consumes no port.
- `WB_R0_FILTER_EN` undefined: rd=0 writes pass through like any other register. Read-side consumers are then responsible for masking r0.

## Structure
- Shared package `wb_pkg`:
  - `wb_req_t` struct {valid, rd[4:0], data[31:0]}.
  - `REG_ADDR_W=5`.
  - `REG_DATA_W=32`.
- Sub-module `wb_late_fifo`:
  - Circular buffer exposing head and head+1 entries with valid bits.
  - Dequeue count 0/1/2, 1-wide enqueue, count output.
- `wb_commit` holds:
  - The port allocator.
  - The WAW compare logic.
  - The output registers.

## Test plan
- Reset, then pipe0 {rd=3, data=0x11} and pipe1 {rd=4, data=0x22} in cycle t → cycle t+1: `we1=1 waddr1=3 wdata1=0x11`, `we2=1 waddr2=4 wdata2=0x22`. In cycle t+2, with no new inputs, `we1=we2=0`.
- Both pipes valid and late offers rd=5..8 on consecutive cycles → all four enqueue and `late_ready` drops to 0. The fifth offer (rd=9, data=0xAA) is held, with `late_valid` kept high. When the pipes go idle, rd=5,6 retire in one cycle on ports 1 and 2, then rd=7,8, then rd=9 (0xAA) on port 1.
- pipe0 invalid, pipe1 rd=2, empty queue, late rd=7 data=0x5A → next cycle: `we1=1 waddr1=7 wdata1=0x5A`, `we2=1 waddr2=2`. Queue stays empty.
- Queue head rd=10 data=0x1, pipe0 rd=10 data=0x2 → head is dropped and count decrements. Port 1 writes rd=10 data=0x2, and no port carries 0x1.
- With `WB_R0_FILTER_EN`: pipe0 rd=0 plus late rd=0 → `we1=we2=0`, and the late offer is accepted with `late_ready` unaffected. Without the macro, the same stimulus gives `we1=1 waddr1=0`.
- Full queue, then `reset` asserted for 1 cycle with pipes valid → next cycle: all outputs 0 and `late_ready=1`. No stale entry is ever written afterwards.
